// File: rtl/seg7_scan_display_if.sv
// rtl/seg7_scan_display_if.sv - load/display bus between a debug-word source and the 7-seg scanner
interface seg7_scan_display_if;
  logic        i_valid;
  logic [31:0] i_data;
  logic [7:0]  o_seg;
  logic [7:0]  o_sel;

  modport master (
    output i_valid,
    output i_data,
    input  o_seg,
    input  o_sel
  );

  modport slave (
    input  i_valid,
    input  i_data,
    output o_seg,
    output o_sel
  );
endinterface

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - 8-digit hex seven-segment scanner; SEG7_LZ_BLANK_EN enables leading-zero blanking
// Latches a 32-bit word and time-multiplexes it across 8 digits, one digit per SCAN_DIV clocks.
module seg7_scan_display #(
  parameter int unsigned SCAN_DIV   = 100_000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  reset,
  seg7_scan_display_if.slave    disp
);

  localparam int unsigned          DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]           ALL_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [31:0]      data_q,    data_d;
  logic [2:0]       idx_q,     idx_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [7:0]       seg_q,     seg_d;
  logic [7:0]       sel_q,     sel_d;

  logic [4:0]       nib_shift;
  logic [3:0]       nibble;
  logic             blank;
  logic [7:0]       seg_al;
  logic [7:0]       sel_al;
  logic             slot_end;

  // Active-low {g,f,e,d,c,b,a} glyphs for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  assign slot_end  = (div_cnt_q == DIV_MAX);
  assign nib_shift = {idx_q, 2'b00};
  assign nibble    = data_q[nib_shift +: 4];

`ifdef SEG7_LZ_BLANK_EN
  // A digit is a leading zero when it and every digit to its left are zero.
  assign blank = (idx_q != 3'd0) && ((data_q >> nib_shift) == 32'd0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    data_d    = data_q;
    idx_d     = idx_q;
    div_cnt_d = div_cnt_q;
    if (disp.i_valid) begin
      data_d = disp.i_data;
    end
    if (slot_end) begin
      div_cnt_d = '0;
      idx_d     = idx_q + 3'd1;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  always_comb begin
    seg_al = blank ? 8'hFF : {1'b1, hex7(nibble)};
    sel_al = ~(8'b1 << idx_q);
    seg_d  = ACTIVE_LOW ? seg_al : ~seg_al;
    sel_d  = ACTIVE_LOW ? sel_al : ~sel_al;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      data_q    <= '0;
      idx_q     <= '0;
      div_cnt_q <= '0;
      seg_q     <= ALL_OFF;
      sel_q     <= ALL_OFF;
    end else begin
      data_q    <= data_d;
      idx_q     <= idx_d;
      div_cnt_q <= div_cnt_d;
      seg_q     <= seg_d;
      sel_q     <= sel_d;
    end
  end

  assign disp.o_seg = seg_q;
  assign disp.o_sel = sel_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - self-checking bench for seg7_scan_display (SCAN_DIV=4 and SCAN_DIV=1 instances)
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, valid;
  logic [31:0] data;

  always #5 clk = ~clk;

  seg7_scan_display_if ifa ();
  seg7_scan_display_if ifb ();

  assign ifa.i_valid = valid;
  assign ifa.i_data  = data;
  assign ifb.i_valid = valid;
  assign ifb.i_data  = data;

  seg7_scan_display #(.SCAN_DIV(4), .ACTIVE_LOW(1'b1)) dut_a (
    .clk_in (clk),
    .reset  (rst_a),
    .disp   (ifa.slave)
  );

  seg7_scan_display #(.SCAN_DIV(1), .ACTIVE_LOW(1'b1)) dut_b (
    .clk_in (clk),
    .reset  (rst_b),
    .disp   (ifb.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] sb_q [$];

  logic [7:0]  HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [15:0] SEQ [8]  = '{16'hFEA1, 16'hFDC6, 16'hFB83, 16'hF788,
                            16'hEF99, 16'hDFB0, 16'hBFA4, 16'h7FF9};
`ifdef SEG7_LZ_BLANK_EN
  localparam logic [7:0] BLK = 8'hFF;
`else
  localparam logic [7:0] BLK = 8'hC0;
`endif

  logic [31:0] m_data_a, m_data_b;
  logic [2:0]  m_idx_a,  m_idx_b;
  int          m_div_a,  m_div_b;

  function automatic logic [15:0] enc(input logic [2:0] k, input logic [31:0] d);
    logic [7:0] seg;
    logic [7:0] sel;
    logic [3:0] nib;
    nib = 4'((d >> (4 * k)) & 32'hF);
    seg = HEX[nib];
`ifdef SEG7_LZ_BLANK_EN
    if (k != 3'd0 && (d >> (4 * k)) == 32'd0) seg = 8'hFF;
`endif
    sel = ~(8'b1 << k);
    return {sel, seg};
  endfunction

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_true(input string tag, input bit ok);
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s observed=0 expected=1", tag);
    end
  endtask

  // One clock: queue the expected outputs, advance the reference state, compare after the edge.
  task automatic tick();
    sb_q.push_back(rst_a ? 16'hFFFF : enc(m_idx_a, m_data_a));
    sb_q.push_back(rst_b ? 16'hFFFF : enc(m_idx_b, m_data_b));
    @(posedge clk);
    if (rst_a) begin
      m_data_a = '0; m_idx_a = '0; m_div_a = 0;
    end else begin
      if (valid) m_data_a = data;
      if (m_div_a == 3) begin m_div_a = 0; m_idx_a = m_idx_a + 3'd1; end
      else m_div_a++;
    end
    if (rst_b) begin
      m_data_b = '0; m_idx_b = '0; m_div_b = 0;
    end else begin
      if (valid) m_data_b = data;
      m_idx_b = m_idx_b + 3'd1;
    end
    #1;
    check16("scan_a", {ifa.o_sel, ifa.o_seg}, sb_q.pop_front());
    check16("scan_b", {ifb.o_sel, ifb.o_seg}, sb_q.pop_front());
  endtask

  function automatic int digit_of(input logic [7:0] sel);
    for (int k = 0; k < 8; k++) begin
      if (sel == 8'(~(8'b1 << k))) return k;
    end
    return -1;
  endfunction

  initial begin
    bit          found;
    logic [7:0]  prev;
    logic [2:0]  old_idx, new_idx;
    logic [3:0]  old_nib;
    int          k;
    logic [7:0]  exp_seg;

    m_data_a = '0; m_idx_a = '0; m_div_a = 0;
    m_data_b = '0; m_idx_b = '0; m_div_b = 0;

    // Reset held 3 clocks with a load attempt that must be ignored.
    rst_a = 1'b1; rst_b = 1'b1; valid = 1'b1; data = 32'hDEAD_BEEF;
    #2;
    repeat (3) tick();
    check16("rst_hold_a", {ifa.o_sel, ifa.o_seg}, 16'hFFFF);
    rst_a = 1'b0; rst_b = 1'b0; valid = 1'b0;
    tick();
    check16("post_rst_digit0", {ifa.o_sel, ifa.o_seg}, 16'hFEC0);

    // Load and align to the start of a digit-0 slot.
    valid = 1'b1; data = 32'h1234_ABCD;
    tick();
    valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev = ifa.o_sel;
      tick();
      if (prev != 8'hFE && ifa.o_sel == 8'hFE) found = 1'b1;
    end
    check_true("align_digit0", found);

    // Two full scans; during the second, i_data churns with i_valid low.
    for (int j = 0; j < 64; j++) begin
      check16("scan_seq", {ifa.o_sel, ifa.o_seg}, SEQ[(j / 4) % 8]);
      if (j >= 32) data = $urandom;
      tick();
    end

    // Load 0 on the same edge as a digit advance.
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (m_div_a == 3) found = 1'b1;
      else tick();
    end
    check_true("find_advance", found);
    old_idx = m_idx_a;
    new_idx = old_idx + 3'd1;
    old_nib = 4'((32'h1234_ABCD >> (4 * old_idx)) & 32'hF);
    valid = 1'b1; data = 32'h0;
    tick();
    valid = 1'b0;
    check16("adv_old_digit", {ifa.o_sel, ifa.o_seg}, {8'(~(8'b1 << old_idx)), HEX[old_nib]});
    tick();
    check16("adv_new_digit", {ifa.o_sel, ifa.o_seg},
            {8'(~(8'b1 << new_idx)), (new_idx == 3'd0) ? 8'hC0 : BLK});

    // Small value: upper digits are leading zeros.
    valid = 1'b1; data = 32'h0000_00A5;
    tick();
    valid = 1'b0;
    tick();
    for (int j = 0; j < 32; j++) begin
      k = digit_of(ifa.o_sel);
      exp_seg = (k == 0) ? 8'h92 : (k == 1) ? 8'h88 : BLK;
      check_true("a5_sel_onecold", k >= 0);
      check16("a5_seg", {8'h00, ifa.o_seg}, {8'h00, exp_seg});
      tick();
    end

    valid = 1'b1; data = 32'h0;
    tick();
    valid = 1'b0;
    tick();
    for (int j = 0; j < 32; j++) begin
      k = digit_of(ifa.o_sel);
      exp_seg = (k == 0) ? 8'hC0 : BLK;
      check16("zero_seg", {8'h00, ifa.o_seg}, {8'h00, exp_seg});
      tick();
    end

    // One-clock reset mid-slot at digit 5.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_idx_a == 3'd5 && m_div_a == 1) found = 1'b1;
      else tick();
    end
    check_true("find_idx5", found);
    rst_a = 1'b1; rst_b = 1'b1;
    tick();
    check16("midrst_a", {ifa.o_sel, ifa.o_seg}, 16'hFFFF);
    check16("midrst_b", {ifb.o_sel, ifb.o_seg}, 16'hFFFF);
    rst_a = 1'b0; rst_b = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      check16("div1_digit", {ifb.o_sel, ifb.o_seg},
              {8'(~(8'b1 << j)), (j == 0) ? 8'hC0 : BLK});
      check16("div4_restart", {8'h00, ifa.o_sel}, {8'h00, (j < 4) ? 8'hFE : 8'hFD});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
